// File: rtl/fetch_queue.sv
// Fetch queue: PC generator feeding a circular buffer of fetch bundles toward decode.
// Defining FETCH_QUEUE_BYPASS_EN lets an empty queue forward the fetched bundle combinationally.
module fetch_queue #(
  parameter int unsigned CORE_WIDTH  = 2,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [31:0]                   pc_addr,
  input  logic [CORE_WIDTH*32-1:0]      instruction_blk,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  input  logic                          deq_ready,
  output logic                          deq_valid,
  output logic [CORE_WIDTH*32-1:0]      deq_instr_blk,
  output logic [31:0]                   deq_pc,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned BlkW = CORE_WIDTH * 32;
  localparam logic [CntW-1:0] Full   = CntW'(QUEUE_DEPTH);
  localparam logic [31:0]     PcStep = 32'(4 * CORE_WIDTH);

  logic [31:0]     pc_q, pc_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [BlkW-1:0] blk_q [QUEUE_DEPTH];
  logic [31:0]     bpc_q [QUEUE_DEPTH];

  logic fetch_fire, bypass, enq, deq;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign fetch_fire = !rst && !redirect_valid && (count_q != Full);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = fetch_fire && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  // Only a buffered head can be popped; an accepted bypass bundle never takes an entry.
  assign deq = deq_ready && (count_q != '0);
  assign enq = fetch_fire && !(bypass && deq_ready);

  assign pc_addr     = pc_q;
  assign queue_count = count_q;

  always_comb begin
    deq_valid     = (count_q != '0);
    deq_instr_blk = blk_q[head_q];
    deq_pc        = bpc_q[head_q];
`ifdef FETCH_QUEUE_BYPASS_EN
    if (bypass) begin
      deq_valid     = 1'b1;
      deq_instr_blk = instruction_blk;
      deq_pc        = pc_q;
    end
`endif
  end

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (fetch_fire) pc_d = pc_q + PcStep;
      if (enq) tail_d = tail_q + 1'b1;
      if (deq) head_d = head_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        blk_q[i] <= '0;
        bpc_q[i] <= '0;
      end
    end else if (enq) begin
      blk_q[tail_q] <= instruction_blk;
      bpc_q[tail_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, PC wrap instance, and randomized traffic
// checked against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned Depth = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        deq_ready = 1'b0;
  logic [31:0] pc_addr, deq_pc;
  logic [63:0] instruction_blk, deq_instr_blk;
  logic        deq_valid;
  logic [2:0]  queue_count;

  logic [31:0] w_pc_addr, w_deq_pc;
  logic [63:0] w_instruction_blk, w_deq_instr_blk;
  logic        w_deq_valid;
  logic [2:0]  w_queue_count;
  logic        w_redirect = 1'b0;
  logic        w_ready = 1'b1;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0000 ^ {a[15:0], 16'h0};
  endfunction

  function automatic logic [63:0] blk_at(input logic [31:0] a);
    return {word_at(a + 32'd4), word_at(a)};
  endfunction

  assign instruction_blk   = blk_at(pc_addr);
  assign w_instruction_blk = blk_at(w_pc_addr);

  fetch_queue #(.CORE_WIDTH(2), .QUEUE_DEPTH(Depth), .RESET_PC(32'h0)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .pc_addr         (pc_addr),
    .instruction_blk (instruction_blk),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .deq_ready       (deq_ready),
    .deq_valid       (deq_valid),
    .deq_instr_blk   (deq_instr_blk),
    .deq_pc          (deq_pc),
    .queue_count     (queue_count)
  );

  fetch_queue #(.CORE_WIDTH(2), .QUEUE_DEPTH(Depth), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk             (clk),
    .rst             (rst),
    .pc_addr         (w_pc_addr),
    .instruction_blk (w_instruction_blk),
    .redirect_valid  (w_redirect),
    .redirect_pc     (32'h0),
    .deq_ready       (w_ready),
    .deq_valid       (w_deq_valid),
    .deq_instr_blk   (w_deq_instr_blk),
    .deq_pc          (w_deq_pc),
    .queue_count     (w_queue_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of {pc, bundle} plus the next fetch address.
  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] blk;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] mpc = 32'h0;

  task automatic model_update();
    bit   fire, byp;
    ent_t e;
    if (rst) begin
      mq.delete();
      mpc = 32'h0;
    end else if (redirect_valid) begin
      mq.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else begin
      fire = (mq.size() < Depth);
      byp  = BypassEn && fire && (mq.size() == 0);
      if (deq_ready && mq.size() > 0) void'(mq.pop_front());
      if (fire && !(byp && deq_ready)) begin
        e.pc  = mpc;
        e.blk = blk_at(mpc);
        mq.push_back(e);
      end
      if (fire) mpc = mpc + 32'd8;
    end
  endtask

  task automatic model_check();
    bit          ev;
    logic [31:0] epc;
    logic [63:0] eblk;
    ev   = (mq.size() > 0);
    epc  = 32'h0;
    eblk = 64'h0;
    if (mq.size() > 0) begin
      epc  = mq[0].pc;
      eblk = mq[0].blk;
    end else if (BypassEn && !rst && !redirect_valid) begin
      ev   = 1'b1;
      epc  = mpc;
      eblk = blk_at(mpc);
    end
    chk("rnd.count", 64'(queue_count), 64'(mq.size()));
    chk("rnd.pc_addr", 64'(pc_addr), 64'(mpc));
    chk("rnd.valid", 64'(deq_valid), 64'(ev));
    if (ev) begin
      chk("rnd.deq_pc", 64'(deq_pc), 64'(epc));
      chk("rnd.deq_blk", deq_instr_blk, eblk);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    bit          rst, rv;
    logic [31:0] rpc;
    bit          rdy, chk;
    int          cnt;
    bit          vld;
    logic [31:0] pca;
    bit          chk_pc;
    logic [31:0] dpc;
  } vec_t;

  localparam int NVec = 25;
  vec_t tbl[NVec];

  function automatic vec_t mk(bit r, bit rv, logic [31:0] rpc, bit rdy, bit c, int cnt, bit v,
                              logic [31:0] pca, bit cp, logic [31:0] dpc);
    vec_t t;
    t.rst = r; t.rv = rv; t.rpc = rpc; t.rdy = rdy; t.chk = c; t.cnt = cnt;
    t.vld = v; t.pca = pca; t.chk_pc = cp; t.dpc = dpc;
    return t;
  endfunction

  initial begin
    // Each row: inputs for the cycle, outputs expected before the closing edge.
    tbl[0]  = mk(1, 0, 0,     0, 0, 0, 0, 0,     0, 0);
    tbl[1]  = mk(0, 0, 0,     1, 1, 0, 0, 0,     1, 0);
    tbl[2]  = mk(0, 0, 0,     1, 1, 1, 1, 8,     1, 0);
    tbl[3]  = mk(0, 0, 0,     1, 1, 1, 1, 16,    1, 8);
    tbl[4]  = mk(0, 0, 0,     0, 1, 1, 1, 24,    1, 16);
    tbl[5]  = mk(0, 0, 0,     0, 1, 2, 1, 32,    1, 16);
    tbl[6]  = mk(0, 0, 0,     0, 1, 3, 1, 40,    1, 16);
    tbl[7]  = mk(0, 0, 0,     0, 1, 4, 1, 48,    1, 16);
    tbl[8]  = mk(0, 0, 0,     0, 1, 4, 1, 48,    1, 16);
    tbl[9]  = mk(1, 0, 0,     0, 1, 4, 1, 48,    1, 16);
    tbl[10] = mk(0, 0, 0,     0, 1, 0, 0, 0,     1, 0);
    tbl[11] = mk(0, 0, 0,     0, 1, 1, 1, 8,     1, 0);
    tbl[12] = mk(0, 0, 0,     0, 1, 2, 1, 16,    1, 0);
    tbl[13] = mk(0, 0, 0,     0, 1, 3, 1, 24,    1, 0);
    tbl[14] = mk(0, 0, 0,     0, 1, 4, 1, 32,    1, 0);
    tbl[15] = mk(0, 0, 0,     0, 1, 4, 1, 32,    1, 0);
    tbl[16] = mk(0, 0, 0,     1, 1, 4, 1, 32,    1, 0);
    tbl[17] = mk(0, 0, 0,     1, 1, 3, 1, 32,    1, 8);
    tbl[18] = mk(0, 0, 0,     1, 1, 3, 1, 40,    1, 16);
    tbl[19] = mk(0, 0, 0,     1, 1, 3, 1, 48,    1, 24);
    tbl[20] = mk(0, 1, 'h103, 0, 1, 3, 1, 56,    1, 32);
    tbl[21] = mk(0, 0, 0,     0, 1, 0, 0, 'h100, 0, 0);
    tbl[22] = mk(0, 0, 0,     0, 1, 1, 1, 'h108, 1, 'h100);
    tbl[23] = mk(1, 1, 'h40,  1, 1, 2, 1, 'h110, 1, 'h100);
    tbl[24] = mk(0, 0, 0,     0, 1, 0, 0, 0,     1, 0);

    // PC wrap on the instance reset to 0xFFFF_FFF8
    rst = 1'b1; deq_ready = 1'b0; redirect_valid = 1'b0;
    tick();
    rst = 1'b0; deq_ready = 1'b1;
    @(negedge clk);
    chk("wrap.pc0", 64'(w_pc_addr), 64'h0000_0000_FFFF_FFF8);
    tick();
    @(negedge clk);
    chk("wrap.pc1", 64'(w_pc_addr), 64'h0);
    tick();

`ifndef FETCH_QUEUE_BYPASS_EN
    for (int i = 0; i < NVec; i++) begin
      rst = tbl[i].rst; redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc; deq_ready = tbl[i].rdy;
      @(negedge clk);
      if (tbl[i].chk) begin
        chk($sformatf("v%0d.count", i), 64'(queue_count), 64'(tbl[i].cnt));
        chk($sformatf("v%0d.valid", i), 64'(deq_valid), 64'(tbl[i].vld));
        chk($sformatf("v%0d.pc_addr", i), 64'(pc_addr), 64'(tbl[i].pca));
        if (tbl[i].chk_pc) begin
          chk($sformatf("v%0d.deq_pc", i), 64'(deq_pc), 64'(tbl[i].dpc));
          chk($sformatf("v%0d.deq_blk", i), deq_instr_blk,
              tbl[i].vld ? blk_at(tbl[i].dpc) : 64'h0);
        end
      end
      tick();
    end
`else
    rst = 1'b1; redirect_valid = 1'b0; deq_ready = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("byp.valid", 64'(deq_valid), 64'h1);
    chk("byp.deq_pc", 64'(deq_pc), 64'h0);
    chk("byp.count", 64'(queue_count), 64'h0);
    tick();
`endif

    for (int n = 0; n < 600; n++) begin
      rst            = ($urandom_range(63) == 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = $urandom();
      deq_ready      = ((n / 100) % 2 == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      @(negedge clk);
      model_check();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
